stream_feeder: RTL and testbench
================================

Name: stream_feeder

Overview:
- Source-side companion to the byte-stream max/second-max tracker.
- Buffers bytes written by a host or testbench and replays them as a `valid_out`/`data_out` beat stream.
- The stream matches the tracker's `valid_in`/`data_in` input exactly.
- A frame of buffered bytes is sent on command, with a programmable idle gap between beats.

Parameters:
- `DATA_W`, 8, beat and byte width.
- `DEPTH`, 16, FIFO entries; power of two, at least 2.
- `GAP_W`, 4, width of the inter-beat gap field.

Ports:
- `clk`  in  1  single clock; rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  push `wr_data` into the FIFO this cycle.
- `wr_data`  in  DATA_W  byte to buffer.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky; a write was attempted while full.
- `start`  in  1  one-cycle pulse; begin sending a frame.
- `gap_cfg`  in  GAP_W  idle cycles inserted after each beat; sampled at start.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse when a frame completes.
- `valid_out`  out  1  beat valid; there is no ready, so the consumer always accepts.
- `data_out`  out  DATA_W  beat data; 0 when `valid_out` is low.

Behaviour:
- Reset (synchronous, `reset`=1 at a rising edge):
  - FIFO flushed; all outputs 0 except `empty`=1.
  - State returns to IDLE.
  - `overflow` cleared.
  - Reset asserted mid-frame aborts the frame; no `done` pulse.
- FSM states IDLE, SEND, GAP, FIN.
- IDLE:
  - On `start`, latch `n_rem = level` (snapshot) and `gap = gap_cfg`.
  - If `n_rem` = 0, go to FIN; otherwise go to SEND.
  - `start` outside IDLE is ignored.
- SEND:
  - Registered output: the cycle after SEND is entered, `valid_out`=1 and `data_out` = FIFO head; the head is popped and `n_rem` decremented.
  - Start-to-first-beat latency is 2 cycles.
  - If `n_rem` becomes 0, go to FIN.
  - Otherwise, if `gap` = 0, stay in SEND (back-to-back beats); else go to GAP.
- GAP:
  - `valid_out`=0 for exactly `gap` cycles, then return to SEND.
- FIN:
  - `done`=1 for one cycle; `busy`=0 in the same cycle; go to IDLE.
  - `start` in the FIN cycle is ignored.
- `busy`=1 in SEND and GAP, and in the cycle after `start` is accepted.
- Writes during a frame:
  - Accepted normally.
  - Bytes written after `start` are not part of the current frame; they stay buffered for the next frame.
- Same-cycle push and pop:
  - When full, the pop frees a slot, so the write is accepted; `level` is unchanged.
  - When empty, no pop can occur, because the snapshot guarantees data is present.
- Write while full and not popping:
  - Byte dropped; `overflow`=1 until reset.
- Pointers wrap modulo DEPTH; `level` is derived from pointers that carry an extra wrap bit.
- `data_out` is forced to 0 whenever `valid_out`=0.

Optional Feature:
- Macro `STREAM_FEEDER_ZERO_SKIP_EN`.
- Defined:
  - A head byte equal to 0 is popped and counts against `n_rem`, but produces no beat.
  - No gap is inserted after a skipped byte.
  - If the last bytes are zero, FIN follows directly.
  - Purpose: avoid zero samples, which the downstream tracker reports as "no result".
- Undefined: zero bytes are sent like any other byte.

Decomposition:
- Package `stream_feeder_pkg` holds:
  - the state enum (IDLE/SEND/GAP/FIN);
  - default localparams `DATA_W_DEF`=8, `DEPTH_DEF`=16, `GAP_W_DEF`=4.
- One sub-module, `stream_feeder_fifo`:
  - synchronous single-clock FIFO;
  - ports: push, pop, `wr_data`, `rd_data`, `full`, `empty`, `level`, `overflow`.
- The top level contains the FSM and output registers only.

Test Plan:
- Reset, write 10,40,25, `gap_cfg`=0, pulse `start`:
  - beats 10,40,25 on three consecutive cycles starting 2 cycles after `start`;
  - `done` pulses the cycle after the last beat;
  - `empty`=1 afterwards.
- Write 7,9, `gap_cfg`=3, `start`:
  - pattern: beat 7, three idle cycles, beat 9, then `done`;
  - `data_out`=0 during the idle cycles.
- Fill 16 bytes (0x01..0x10), write 0xFF while full:
  - `overflow`=1 and `level`=16;
  - the frame sends 0x01..0x10 only.
- `start` with an empty FIFO:
  - `done` 2 cycles later;
  - no `valid_out`.
- Mid-frame case: write 1..4, `start`, write 5 during the 2nd beat, and assert `reset` after the 3rd beat:
  - beats 1,2,3 only;
  - no `done`; `level`=0; outputs 0.
- With `STREAM_FEEDER_ZERO_SKIP_EN`, write 0,5,0,8, `gap_cfg`=0:
  - beats 5,8 only, then `done`.
- Without the macro, same stimulus:
  - beats 0,5,0,8.

Source files
------------

// File: rtl/stream_feeder_pkg.sv
// Shared types and default sizes for the stream_feeder source block:
// the frame-sequencing state encoding and the default parameter values.
package stream_feeder_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;
    localparam int GAP_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        FIN
    } state_t;

endpackage

// File: rtl/stream_feeder_fifo.sv
// Single-clock byte FIFO for stream_feeder. Pointers carry an extra wrap bit
// so occupancy is their difference; a write while full and not popping is dropped.
module stream_feeder_fifo
    import stream_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wrPtr;
    logic [AW:0]       r_rdPtr;
    logic              r_overflow;
    logic              w_full;
    logic              w_empty;
    logic              w_doPop;
    logic              w_doPush;

    assign w_empty  = (r_wrPtr == r_rdPtr);
    assign w_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    // A pop in the same cycle frees a slot, so a push while full still lands.
    assign w_doPop  = pop && !w_empty;
    assign w_doPush = push && (!w_full || w_doPop);

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + (AW+1)'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + (AW+1)'(1);
            end
            if (push && w_full && !w_doPop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rd_data  = r_mem[r_rdPtr[AW-1:0]];
    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = r_wrPtr - r_rdPtr;
    assign overflow = r_overflow;

endmodule

// File: rtl/stream_feeder.sv
// Replays buffered bytes as a valid_out/data_out beat stream with a programmable gap.
// Optional STREAM_FEEDER_ZERO_SKIP_EN: zero head bytes are consumed without producing a beat.
module stream_feeder
    import stream_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int GAP_W  = GAP_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   start,
    input  logic [GAP_W-1:0]       gap_cfg,
    output logic                   busy,
    output logic                   done,
    output logic                   valid_out,
    output logic [DATA_W-1:0]      data_out
);

    localparam int LW = $clog2(DEPTH) + 1;
`ifdef STREAM_FEEDER_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    state_t             r_state;
    state_t             w_nextState;
    logic [LW-1:0]      r_nRem;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   r_gapCnt;
    logic               r_valid;
    logic [DATA_W-1:0]  r_data;
    logic               r_done;
    logic               r_busy;
    logic               w_pop;
    logic               w_skip;
    logic               w_beat;
    logic [DATA_W-1:0]  w_head;
    logic [LW-1:0]      w_level;

    stream_feeder_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (wr_en),
        .pop      (w_pop),
        .wr_data  (wr_data),
        .rd_data  (w_head),
        .full     (full),
        .empty    (empty),
        .level    (w_level),
        .overflow (overflow)
    );

    // The level snapshot taken at start guarantees the FIFO is non-empty in SEND.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_skip      = ZERO_SKIP && (w_head == '0);
        w_beat      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = (w_level == '0) ? FIN : SEND;
                end
            end
            SEND: begin
                w_pop  = 1'b1;
                w_beat = !w_skip;
                if (r_nRem == LW'(1)) begin
                    w_nextState = FIN;
                end else if ((r_gap == '0) || w_skip) begin
                    w_nextState = SEND;
                end else begin
                    w_nextState = GAP;
                end
            end
            GAP: begin
                if (r_gapCnt <= GAP_W'(1)) begin
                    w_nextState = SEND;
                end
            end
            FIN: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_nRem   <= '0;
            r_gap    <= '0;
            r_gapCnt <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_valid <= w_beat;
            r_data  <= w_beat ? w_head : '0;
            r_done  <= (r_state == FIN);
            r_busy  <= (w_nextState != IDLE);

            if ((r_state == IDLE) && start) begin
                r_nRem <= w_level;
                r_gap  <= gap_cfg;
            end else if (w_pop) begin
                r_nRem <= r_nRem - LW'(1);
            end

            if ((r_state == SEND) && (w_nextState == GAP)) begin
                r_gapCnt <= r_gap;
            end else if (r_state == GAP) begin
                r_gapCnt <= r_gapCnt - GAP_W'(1);
            end
        end
    end

    assign level     = w_level;
    assign valid_out = r_valid;
    assign data_out  = r_data;
    assign done      = r_done;
    assign busy      = r_busy;

endmodule

// File: tb/tb_stream_feeder.sv
// Scoreboard bench for stream_feeder: a model FIFO builds the per-cycle beat
// pattern at start, which is popped and compared as the DUT streams.
module tb_stream_feeder;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int GAP_W  = 4;
    localparam int LW     = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic [GAP_W-1:0]  gap_cfg;
    logic              full;
    logic              empty;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              busy;
    logic              done;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;

    int nChecks = 0;
    int nPass   = 0;
    int modelFifo[$];
    int expQ[$];

    stream_feeder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .GAP_W  (GAP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .start     (start),
        .gap_cfg   (gap_cfg),
        .busy      (busy),
        .done      (done),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeByte(input int b);
        wr_en   = 1'b1;
        wr_data = 8'(b);
        tick();
        wr_en   = 1'b0;
        if (modelFifo.size() < DEPTH) modelFifo.push_back(b);
    endtask

    // Per-cycle expectation from the cycle after SEND entry: byte value, or -1 for idle.
    task automatic buildPattern(input int gap);
        int frame[$];
        bit last;
        frame = modelFifo;
        modelFifo.delete();
        for (int i = 0; i < frame.size(); i++) begin
            last = (i == frame.size() - 1);
`ifdef STREAM_FEEDER_ZERO_SKIP_EN
            if (frame[i] == 0) begin
                expQ.push_back(-1);
                continue;
            end
`endif
            expQ.push_back(frame[i]);
            if (!last) repeat (gap) expQ.push_back(-1);
        end
    endtask

    task automatic pulseStart(input int gap);
        gap_cfg = GAP_W'(gap);
        start   = 1'b1;
        buildPattern(gap);
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; gap_cfg = '0;
        tick();
        tick();
        reset = 1'b0;
        modelFifo.delete();
        expQ.delete();
        nChecks++;
        if ({valid_out, done, busy, full, empty, overflow, level, data_out} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0})
            $display("[TB] FAIL reset_outputs: got v%0b d%0b b%0b f%0b e%0b o%0b l%0d q%0h want e=1 rest 0",
                     valid_out, done, busy, full, empty, overflow, level, data_out);
        else nPass++;
    endtask

    task automatic test_back_to_back();
        writeByte(10); writeByte(40); writeByte(25);
        nChecks++;
        if (level !== 5'd3) $display("[TB] FAIL b2b_level: got %0d want 3", level);
        else nPass++;
        pulseStart(0);
        nChecks++;
        if (busy !== 1'b1 || valid_out !== 1'b0)
            $display("[TB] FAIL b2b_cycle1: got busy %0b valid %0b want 1 0", busy, valid_out);
        else nPass++;
        while (expQ.size() > 0) begin
            int e;
            tick();
            e = expQ.pop_front();
            nChecks++;
            if (e < 0 ? (valid_out !== 1'b0 || data_out !== 8'd0)
                      : (valid_out !== 1'b1 || data_out !== 8'(e)))
                $display("[TB] FAIL b2b_beat: got v%0b %0d want %0d", valid_out, data_out, e);
            else nPass++;
        end
        tick();
        nChecks++;
        if ({done, busy, valid_out} !== 3'b100)
            $display("[TB] FAIL b2b_done: got done%0b busy%0b v%0b want 1 0 0", done, busy, valid_out);
        else nPass++;
        tick();
        nChecks++;
        if ({done, empty, level} !== {1'b0, 1'b1, 5'd0})
            $display("[TB] FAIL b2b_after: got done%0b empty%0b level%0d want 0 1 0", done, empty, level);
        else nPass++;
    endtask

    task automatic test_gap();
        writeByte(7); writeByte(9);
        pulseStart(3);
        nChecks++;
        if (busy !== 1'b1) $display("[TB] FAIL gap_busy: got %0b want 1", busy);
        else nPass++;
        while (expQ.size() > 0) begin
            int e;
            tick();
            e = expQ.pop_front();
            nChecks++;
            if (e < 0 ? (valid_out !== 1'b0 || data_out !== 8'd0)
                      : (valid_out !== 1'b1 || data_out !== 8'(e)))
                $display("[TB] FAIL gap_beat: got v%0b %0d want %0d", valid_out, data_out, e);
            else nPass++;
        end
        tick();
        nChecks++;
        if ({done, busy, valid_out} !== 3'b100)
            $display("[TB] FAIL gap_done: got done%0b busy%0b v%0b want 1 0 0", done, busy, valid_out);
        else nPass++;
        tick();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 16; i++) writeByte(i);
        nChecks++;
        if (full !== 1'b1) $display("[TB] FAIL ovf_full: got %0b want 1", full);
        else nPass++;
        writeByte(8'hFF);
        nChecks++;
        if ({overflow, level} !== {1'b1, 5'd16})
            $display("[TB] FAIL ovf_flag: got ovf%0b level%0d want 1 16", overflow, level);
        else nPass++;
        pulseStart(0);
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        modelFifo.push_back(8'hAA);
        tick();
        wr_en = 1'b0;
        nChecks++;
        if (level !== 5'd16) $display("[TB] FAIL ovf_pushpop_level: got %0d want 16", level);
        else nPass++;
        begin
            int e;
            e = expQ.pop_front();
            nChecks++;
            if (valid_out !== 1'b1 || data_out !== 8'(e))
                $display("[TB] FAIL ovf_first_beat: got v%0b %0h want %0h", valid_out, data_out, e);
            else nPass++;
        end
        while (expQ.size() > 0) begin
            int e;
            tick();
            e = expQ.pop_front();
            nChecks++;
            if (valid_out !== 1'b1 || data_out !== 8'(e))
                $display("[TB] FAIL ovf_beat: got v%0b %0h want %0h", valid_out, data_out, e);
            else nPass++;
        end
        tick();
        nChecks++;
        if ({done, valid_out, level, overflow} !== {1'b1, 1'b0, 5'd1, 1'b1})
            $display("[TB] FAIL ovf_done: got done%0b v%0b level%0d ovf%0b want 1 0 1 1",
                     done, valid_out, level, overflow);
        else nPass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        modelFifo.delete();
        nChecks++;
        if ({overflow, empty, level} !== {1'b0, 1'b1, 5'd0})
            $display("[TB] FAIL ovf_clear: got ovf%0b empty%0b level%0d want 0 1 0", overflow, empty, level);
        else nPass++;
    endtask

    task automatic test_empty_start();
        pulseStart(5);
        nChecks++;
        if ({busy, valid_out, done} !== 3'b100)
            $display("[TB] FAIL empty_cycle1: got busy%0b v%0b done%0b want 1 0 0", busy, valid_out, done);
        else nPass++;
        while (expQ.size() > 0) begin
            int e;
            tick();
            e = expQ.pop_front();
            nChecks++;
            $display("[TB] FAIL empty_beat: got pattern entry %0d want none", e);
        end
        tick();
        nChecks++;
        if ({done, busy, valid_out} !== 3'b100)
            $display("[TB] FAIL empty_done: got done%0b busy%0b v%0b want 1 0 0", done, busy, valid_out);
        else nPass++;
        tick();
        nChecks++;
        if (done !== 1'b0) $display("[TB] FAIL empty_done_pulse: got %0b want 0", done);
        else nPass++;
    endtask

    task automatic test_mid_frame_reset();
        int sawDone;
        for (int i = 1; i <= 4; i++) writeByte(i);
        pulseStart(0);
        for (int k = 0; k < 3; k++) begin
            int e;
            tick();
            e = expQ.pop_front();
            nChecks++;
            if (valid_out !== 1'b1 || data_out !== 8'(e))
                $display("[TB] FAIL mid_beat: got v%0b %0d want %0d", valid_out, data_out, e);
            else nPass++;
            if (k == 1) begin
                wr_en   = 1'b1;
                wr_data = 8'd5;
            end else begin
                wr_en = 1'b0;
            end
        end
        nChecks++;
        if (level !== 5'd2) $display("[TB] FAIL mid_level: got %0d want 2", level);
        else nPass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expQ.delete();
        modelFifo.delete();
        nChecks++;
        if ({valid_out, done, busy, full, empty, overflow, level, data_out} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0})
            $display("[TB] FAIL mid_reset_outputs: got v%0b d%0b b%0b e%0b l%0d q%0h want e=1 rest 0",
                     valid_out, done, busy, empty, level, data_out);
        else nPass++;
        sawDone = 0;
        repeat (4) begin
            tick();
            if (done === 1'b1 || valid_out === 1'b1) sawDone = 1;
        end
        nChecks++;
        if (sawDone !== 0) $display("[TB] FAIL mid_no_done: got activity %0d want 0", sawDone);
        else nPass++;
    endtask

    task automatic test_zero_bytes();
        writeByte(0); writeByte(5); writeByte(0); writeByte(8);
        pulseStart(0);
        while (expQ.size() > 0) begin
            int e;
            tick();
            e = expQ.pop_front();
            nChecks++;
            if (e < 0 ? (valid_out !== 1'b0 || data_out !== 8'd0)
                      : (valid_out !== 1'b1 || data_out !== 8'(e)))
                $display("[TB] FAIL zero_beat: got v%0b %0d want %0d", valid_out, data_out, e);
            else nPass++;
        end
        tick();
        nChecks++;
        if ({done, valid_out, empty} !== 3'b101)
            $display("[TB] FAIL zero_done: got done%0b v%0b empty%0b want 1 0 1", done, valid_out, empty);
        else nPass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gap();
        test_overflow();
        test_empty_start();
        test_mid_frame_reset();
        test_zero_bytes();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
